// File: rtl/logic_fold_unit.sv
// Multi-cycle bitwise fold engine: reduces a stream of len words with AND/OR/XOR/NOR.
// Define LOGIC_FOLD_PARITY_EN to add the registered out_parity output.
module logic_fold_unit #(
    parameter int  WIDTH   = 32,
    parameter int  MAX_LEN = 16,
    localparam int CW      = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CW-1:0]    len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef LOGIC_FOLD_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR, OP_NOR} op_t;
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    state_t           state;
    op_t              op_q;
    logic [CW-1:0]    len_q;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic [CW-1:0]    len_clamped;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] done_data;
    op_t              load_op;
    logic             start_empty;
    logic             last_beat;
    logic             load_done;

    function automatic logic [WIDTH-1:0] identity(input op_t o);
        return (o == OP_AND) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    endfunction

    assign len_clamped = (len > CW'(MAX_LEN)) ? CW'(MAX_LEN) : len;
    assign count_next  = count + 1'b1;
    assign start_empty = (state == S_IDLE) && start && (len_clamped == '0);
    assign last_beat   = (state == S_ACCUM) && in_valid && (count_next == len_q);
    assign load_done   = start_empty || last_beat;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        acc_next = acc;
        case (op_q)
            OP_AND:  acc_next = acc & in_data;
            OP_XOR:  acc_next = acc ^ in_data;
            default: acc_next = acc | in_data;   // NOR accumulates as OR
        endcase
    end

    // Value captured into out_data when entering DONE: either the empty-fold
    // identity (straight from IDLE) or the final accumulator including this beat.
    always_comb begin
        load_op   = (state == S_IDLE) ? op_t'(op) : op_q;
        load_val  = (state == S_IDLE) ? identity(op_t'(op)) : acc_next;
        done_data = (load_op == OP_NOR) ? ~load_val : load_val;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            op_q      <= OP_AND;
            len_q     <= '0;
            count     <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op_t'(op);
                        len_q <= len_clamped;
                        count <= '0;
                        acc   <= identity(op_t'(op));
                        busy  <= 1'b1;
                        if (len_clamped == '0) begin
                            out_data  <= done_data;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        acc   <= acc_next;
                        count <= count_next;
                        if (last_beat) begin
                            out_data  <= done_data;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

`ifdef LOGIC_FOLD_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            out_parity <= 1'b0;
        end else if (load_done) begin
            out_parity <= ^done_data;
        end
    end
`else
    // Without the parity output, load_done only documents the capture point.
    logic unused_load_done;
    assign unused_load_done = load_done;
`endif

endmodule

// File: tb/tb_logic_fold_unit.sv
// Self-checking bench for logic_fold_unit: directed spec scenarios plus
// randomized folds compared against a simple behavioural fold model.
module tb_logic_fold_unit;

    localparam int WIDTH   = 32;
    localparam int MAX_LEN = 16;
    localparam int CW      = $clog2(MAX_LEN + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       op;
    logic [CW-1:0]    len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef LOGIC_FOLD_PARITY_EN
    logic             out_parity;
`endif

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] words[$];

    logic_fold_unit #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef LOGIC_FOLD_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: fold the first n words with the chosen operation.
    function automatic logic [WIDTH-1:0] ref_fold(input logic [1:0] o, input int n);
        logic [WIDTH-1:0] r;
        r = (o == 2'd0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        for (int i = 0; i < n; i++) begin
            case (o)
                2'd0:    r = r & words[i];
                2'd2:    r = r ^ words[i];
                default: r = r | words[i];
            endcase
        end
        if (o == 2'd3) r = ~r;
        return r;
    endfunction

    // One complete fold: start, feed words (with gaps), hold DONE for bp cycles, drain.
    task automatic run_fold(input logic [1:0] f_op, input int f_len, input int gap,
                            input int bp, input int start_at, input logic [WIDTH-1:0] exp);
        int eff;
        eff = (f_len > MAX_LEN) ? MAX_LEN : f_len;
        start = 1'b1;
        op    = f_op;
        len   = CW'(f_len);
        step();
        start = 1'b0;
        op    = 2'($urandom);
        len   = CW'($urandom_range(0, 20));
        check("busy_after_start", busy, 1);
        for (int i = 0; i < eff; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                step();
                check("stall_no_done", out_valid, 0);
            end
            check("in_ready_accum", in_ready, 1);
            check("no_early_valid", out_valid, 0);
            in_valid = 1'b1;
            in_data  = words[i];
            if (i == start_at) begin
                start = 1'b1;
                op    = 2'd0;
                len   = CW'(1);
            end
            step();
            start = 1'b0;
        end
        // Junk word kept valid through DONE must never be absorbed.
        in_valid = 1'b1;
        in_data  = $urandom;
        check("out_valid_done", out_valid, 1);
        check("in_ready_done", in_ready, 0);
        check("out_data", out_data, exp);
`ifdef LOGIC_FOLD_PARITY_EN
        check("out_parity", out_parity, ^exp);
`endif
        for (int b = 0; b < bp; b++) begin
            step();
            check("bp_valid", out_valid, 1);
            check("bp_data_stable", out_data, exp);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_valid", out_valid, 0);
        check("data_held_idle", out_data, exp);
        step();
        check("no_second_fold", busy, 0);
    endtask

    initial begin
        logic [1:0] r_op;
        int         r_len;
        reset     = 1'b1;
        start     = 1'b0;
        op        = 2'd0;
        len       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        reset = 1'b0;
        step();

        // XOR fold, continuous input
        words = '{32'hFFFF0000, 32'h0F0F0F0F, 32'h00000001};
        run_fold(2'd2, 3, 0, 0, -1, 32'hF0F00F0E);

        // NOR with 5 cycles of backpressure
        words = '{32'h00000000, 32'h80000000};
        run_fold(2'd3, 2, 0, 5, -1, 32'h7FFFFFFF);

        // AND with 2-cycle input gaps
        words = '{32'hFFFFFFFF, 32'hF0F0FFFF, 32'hFF00FFFF, 32'hFFFF00FF};
        run_fold(2'd0, 4, 2, 0, -1, 32'hF00000FF);

        // Empty folds return the identity result
        words.delete();
        run_fold(2'd0, 0, 0, 1, -1, 32'hFFFFFFFF);
        run_fold(2'd3, 0, 0, 0, -1, 32'hFFFFFFFF);
        run_fold(2'd2, 0, 0, 0, -1, 32'h00000000);

        // Clamp: len=20 closes after MAX_LEN beats
        words.delete();
        for (int i = 0; i < MAX_LEN; i++) words.push_back($urandom);
        run_fold(2'd1, 20, 0, 1, -1, ref_fold(2'd1, MAX_LEN));

        // Reset mid-fold after 3 beats
        words.delete();
        for (int i = 0; i < 8; i++) words.push_back($urandom);
        start = 1'b1;
        op    = 2'd2;
        len   = CW'(8);
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = words[i];
            step();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        reset    = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        words = '{32'h00000005};
        run_fold(2'd1, 1, 0, 0, -1, 32'h00000005);

        // start pulsed during ACCUM is ignored
        words.delete();
        for (int i = 0; i < 4; i++) words.push_back($urandom);
        run_fold(2'd2, 4, 0, 0, 1, ref_fold(2'd2, 4));

        // Randomized folds
        for (int n = 0; n < 25; n++) begin
            r_op  = 2'($urandom);
            r_len = $urandom_range(0, 20);
            words.delete();
            for (int i = 0; i < MAX_LEN; i++) words.push_back($urandom);
            run_fold(r_op, r_len, $urandom_range(0, 2), $urandom_range(0, 3), -1,
                     ref_fold(r_op, (r_len > MAX_LEN) ? MAX_LEN : r_len));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
